// File: rtl/cpu_control_pkg.sv
// Shared CPU definitions: ALU functions, PC source select, opcodes and
// controller state encoding, plus the strobe bundle shared by the decoder
// and the controller.
package opcodes;

  typedef enum logic [2:0] {
    ALU_PASSA = 3'd0,
    ALU_ADD   = 3'd1,
    ALU_SUB   = 3'd2,
    ALU_AND   = 3'd3,
    ALU_OR    = 3'd4
  } alu_functions_t;

  typedef enum logic {
    PcInc = 1'b0,
    PcJmp = 1'b1
  } PcSel_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LDIH = 4'h2,
    OP_LD   = 4'h3,
    OP_ST   = 4'h4,
    OP_ADD  = 4'h5,
    OP_SUB  = 4'h6,
    OP_AND  = 4'h7,
    OP_OR   = 4'h8,
    OP_ADDI = 4'h9,
    OP_IN   = 4'hA,
    OP_JMP  = 4'hB,
    OP_JZ   = 4'hC,
    OP_JMPI = 4'hD,
    OP_RSVD = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    EXEC    = 3'd2,
    WAIT_IO = 3'd3,
    HALT    = 3'd4
  } ctrl_state_t;

  // What the controller does after EXEC: finish the instruction normally,
  // park in WAIT_IO for the switch handshake, or stop.
  typedef enum logic [1:0] {
    NXT_DONE    = 2'd0,
    NXT_WAIT_IO = 2'd1,
    NXT_HALT    = 2'd2
  } next_hint_t;

  typedef struct packed {
    logic           reg_we;
    logic           imm_sel;
    logic           wdata_sel;
    logic           acc_store;
    logic           op1_sel;
    logic           pc_we;
    alu_functions_t alu_op;
    PcSel_t         pc_sel;
  } strobes_t;

  localparam strobes_t STROBES_OFF = '{
    reg_we:    1'b0,
    imm_sel:   1'b0,
    wdata_sel: 1'b0,
    acc_store: 1'b0,
    op1_sel:   1'b0,
    pc_we:     1'b0,
    alu_op:    ALU_PASSA,
    pc_sel:    PcInc
  };

endpackage

// File: rtl/cpu_control_instr_decode.sv
// Combinational instruction decoder: opcode and accumulator-zero flag in,
// datapath strobe bundle and next-state hint out. Only meaningful in EXEC.
module instr_decode
  import opcodes::*;
(
  input  opcode_t    i_opcode,
  input  logic       i_acc_zero,
  output strobes_t   o_strobes,
  output next_hint_t o_next
);

  // Opcode to strobe map; every instruction starts from all-off/PASSA/PcInc.
  always_comb begin
    o_strobes = STROBES_OFF;
    o_next    = NXT_DONE;
    case (i_opcode)
      OP_NOP, OP_RSVD: begin
        o_strobes.pc_we = 1'b1;
      end
      OP_LDI: begin
        o_strobes.op1_sel   = 1'b1;
        o_strobes.acc_store = 1'b1;
        o_strobes.pc_we     = 1'b1;
      end
      OP_LDIH: begin
        o_strobes.op1_sel   = 1'b1;
        o_strobes.imm_sel   = 1'b1;
        o_strobes.acc_store = 1'b1;
        o_strobes.pc_we     = 1'b1;
      end
      OP_LD: begin
        o_strobes.acc_store = 1'b1;
        o_strobes.pc_we     = 1'b1;
      end
      OP_ST: begin
        o_strobes.reg_we = 1'b1;
        o_strobes.pc_we  = 1'b1;
      end
      OP_ADD: begin
        o_strobes.alu_op    = ALU_ADD;
        o_strobes.acc_store = 1'b1;
        o_strobes.pc_we     = 1'b1;
      end
      OP_SUB: begin
        o_strobes.alu_op    = ALU_SUB;
        o_strobes.acc_store = 1'b1;
        o_strobes.pc_we     = 1'b1;
      end
      OP_AND: begin
        o_strobes.alu_op    = ALU_AND;
        o_strobes.acc_store = 1'b1;
        o_strobes.pc_we     = 1'b1;
      end
      OP_OR: begin
        o_strobes.alu_op    = ALU_OR;
        o_strobes.acc_store = 1'b1;
        o_strobes.pc_we     = 1'b1;
      end
      OP_ADDI: begin
        o_strobes.op1_sel   = 1'b1;
        o_strobes.alu_op    = ALU_ADD;
        o_strobes.acc_store = 1'b1;
        o_strobes.pc_we     = 1'b1;
      end
      OP_IN: begin
        // Register write and PC advance happen later, in WAIT_IO.
        o_next = NXT_WAIT_IO;
      end
      OP_JMP: begin
        o_strobes.pc_we  = 1'b1;
        o_strobes.pc_sel = PcJmp;
      end
      OP_JZ: begin
        o_strobes.pc_we  = 1'b1;
        o_strobes.pc_sel = i_acc_zero ? PcJmp : PcInc;
      end
      OP_JMPI: begin
        o_strobes.op1_sel = 1'b1;
        o_strobes.pc_we   = 1'b1;
        o_strobes.pc_sel  = PcJmp;
      end
      OP_HALT: begin
        o_next = NXT_HALT;
      end
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle sequencer for the accumulator datapath. Only the state is
// registered; every output is decoded from the state and the instruction
// word, so reset clears all strobes immediately.
//
// state   | meaning
// IDLE    | paused, waiting for Run
// FETCH   | instruction word being read from program memory
// EXEC    | decoded strobes driven for one cycle
// WAIT_IO | IN instruction waiting for SwValid
// HALT    | stopped until reset
module cpu_control
  import opcodes::*;
#(
  parameter int n = 8
) (
  input  logic           Clock,
  input  logic           nReset,
  input  logic [n-1:0]   MemData,
  input  logic           AccZero,
  input  logic           Run,
  input  logic           SwValid,
  output logic           SwAck,
  output logic           RegWe,
  output logic           ImmSel,
  output logic           WDataSel,
  output logic           AccStore,
  output logic           Op1Sel,
  output logic           PcWe,
  output alu_functions_t AluOp,
  output PcSel_t         PcSel,
  output logic           Halted
);

  ctrl_state_t r_state;
  opcode_t     w_opcode;
  strobes_t    w_dec_strobes;
  next_hint_t  w_next;
  strobes_t    w_out;
  logic        w_unused_mem;

  // The low nibble (register index / immediate) is consumed by the datapath.
  assign w_opcode     = opcode_t'(MemData[7:4]);
  assign w_unused_mem = ^MemData;

  instr_decode u_decode (
    .i_opcode   (w_opcode),
    .i_acc_zero (AccZero),
    .o_strobes  (w_dec_strobes),
    .o_next     (w_next)
  );

  // State register; Run is only looked at in IDLE and at instruction end.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (Run) r_state <= FETCH;
        FETCH:   r_state <= EXEC;
        EXEC: begin
          case (w_next)
            NXT_WAIT_IO: r_state <= WAIT_IO;
            NXT_HALT:    r_state <= HALT;
            default:     r_state <= Run ? FETCH : IDLE;
          endcase
        end
        WAIT_IO: if (SwValid) r_state <= Run ? FETCH : IDLE;
        HALT:    r_state <= HALT;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output decode from state; WAIT_IO completes the IN write in one cycle.
  always_comb begin
    w_out  = STROBES_OFF;
    SwAck  = 1'b0;
    Halted = 1'b0;
    case (r_state)
      EXEC: w_out = w_dec_strobes;
      WAIT_IO: begin
        if (SwValid) begin
          w_out.reg_we    = 1'b1;
          w_out.wdata_sel = 1'b1;
          w_out.pc_we     = 1'b1;
          SwAck           = 1'b1;
        end
      end
      HALT: Halted = 1'b1;
      default: ;
    endcase
  end

  assign RegWe    = w_out.reg_we;
  assign ImmSel   = w_out.imm_sel;
  assign WDataSel = w_out.wdata_sel;
  assign AccStore = w_out.acc_store;
  assign Op1Sel   = w_out.op1_sel;
  assign PcWe     = w_out.pc_we;
  assign AluOp    = w_out.alu_op;
  assign PcSel    = w_out.pc_sel;

endmodule
